// File: rtl/line_feeder_pkg.sv
// Shared definitions for the line feeder and the per-line processing wrapper.
package line_feeder_pkg;

    localparam int WIDTH  = 1600;
    localparam int HEIGHT = 900;
    localparam int DATA_W = 32;
    localparam int POS_W  = 12;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_SERVE    = 2'd2
    } serve_state_t;

    // Linear line-RAM address of pixel x in a bank; bank 1 sits right after bank 0.
    function automatic pos_t bank_addr(input logic bank, input pos_t x, input int unsigned line_pix);
        return bank ? pos_t'(line_pix) + x : x;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: one write port, one read port with a resettable output register.
module line_bank_ram
    import line_feeder_pkg::*;
#(
    parameter int DEPTH = 2 * WIDTH,
    parameter int AW    = POS_W,
    parameter int DW    = DATA_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port output register; holds the last pulled pixel between reads.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_feeder.sv
// Ping-pong line buffer between the frame reader and the per-line processing wrapper.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | waiting for the read bank to hold a complete line
//  ST_ANNOUNCE | READ_LINE_DONE pulse cycle, READ_POSY carries the line's Y
//  ST_SERVE    | each IN_DE returns the next pixel of the read bank
module line_feeder
    import line_feeder_pkg::*;
#(
    parameter int LINE_PIX    = WIDTH,
    parameter int FRAME_LINES = HEIGHT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic              READ_LINE_DONE,
    output logic [POS_W-1:0]  READ_POSY,
    input  logic              IN_DE,
    output logic [DATA_W-1:0] IN_DATA,
    output logic              ERR
);

    localparam pos_t LAST_X = pos_t'(LINE_PIX - 1);
    localparam pos_t LAST_Y = pos_t'(FRAME_LINES - 1);

    logic [1:0]   full;
    pos_t         posy [2];
    logic         wb;
    logic         rb;
    pos_t         wx;
    pos_t         rx;
    pos_t         ly;
    logic         ready_en;
    serve_state_t state;

    logic s_hs;
    logic fill_done;
    logic rd_en;
    logic serve_done;

    // ready_en keeps S_READY low while reset is held, independent of the bank flags.
    assign S_READY    = ready_en & ~full[wb];
    assign s_hs       = S_VALID & S_READY;
    assign fill_done  = s_hs && (wx == LAST_X);
    assign rd_en      = (state == ST_SERVE) && IN_DE;
    assign serve_done = rd_en && (rx == LAST_X);

    // Fill side: pixel column, write bank, and the frame line counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_en <= 1'b0;
            wb       <= 1'b0;
            wx       <= '0;
            ly       <= '0;
            posy[0]  <= '0;
            posy[1]  <= '0;
        end else begin
            ready_en <= 1'b1;
            if (s_hs) begin
                if (fill_done) begin
                    wx       <= '0;
                    wb       <= ~wb;
                    posy[wb] <= ly;
                    ly       <= (ly == LAST_Y) ? '0 : ly + 1'b1;
                end else begin
                    wx <= wx + 1'b1;
                end
            end
        end
    end

    // Bank full flags: fill sets, serve clears; the two never target the same bank at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (fill_done && (wb == 1'(b))) full[b] <= 1'b1;
                else if (serve_done && (rb == 1'(b))) full[b] <= 1'b0;
            end
        end
    end

    // Serve FSM with registered announce outputs and the sticky protocol error.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= ST_IDLE;
            rb             <= 1'b0;
            rx             <= '0;
            READ_LINE_DONE <= 1'b0;
            READ_POSY      <= '0;
            ERR            <= 1'b0;
        end else begin
            READ_LINE_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (IN_DE) ERR <= 1'b1;
                    if (full[rb]) begin
                        state          <= ST_ANNOUNCE;
                        READ_LINE_DONE <= 1'b1;
                        READ_POSY      <= posy[rb];
                        rx             <= '0;
                    end
                end
                ST_ANNOUNCE: begin
                    if (IN_DE) ERR <= 1'b1;
                    state <= ST_SERVE;
                end
                ST_SERVE: begin
                    if (IN_DE) begin
                        if (rx == LAST_X) begin
                            rx    <= '0;
                            rb    <= ~rb;
                            state <= ST_IDLE;
                        end else begin
                            rx <= rx + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    line_bank_ram #(
        .DEPTH (2 * LINE_PIX),
        .AW    (POS_W),
        .DW    (DATA_W)
    ) u_ram (
        .CLK   (CLK),
        .RST   (RST),
        .we    (s_hs),
        .waddr (bank_addr(wb, wx, LINE_PIX)),
        .wdata (S_DATA),
        .re    (rd_en),
        .raddr (bank_addr(rb, rx, LINE_PIX)),
        .rdata (IN_DATA)
    );

endmodule

// File: tb/tb_line_feeder.sv
`timescale 1ns/1ps
module tb_line_feeder;
    import line_feeder_pkg::*;

    localparam int W = 1600;
    localparam int H = 12;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic [31:0] S_DATA = '0;
    logic        READ_LINE_DONE;
    logic [11:0] READ_POSY;
    logic        IN_DE = 1'b0;
    logic [31:0] IN_DATA;
    logic        ERR;

    line_feeder #(.LINE_PIX(W), .FRAME_LINES(H)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .S_VALID        (S_VALID),
        .S_READY        (S_READY),
        .S_DATA         (S_DATA),
        .READ_LINE_DONE (READ_LINE_DONE),
        .READ_POSY      (READ_POSY),
        .IN_DE          (IN_DE),
        .IN_DATA        (IN_DATA),
        .ERR            (ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int last_de_cyc = 0;
    int beats_taken = 0;
    int ann_cyc = 0;
    logic [11:0] ann_q [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Buffered pixels in arrival order, Y values of complete buffered lines,
    // and a serve phase: 0 waiting, 1 announcing, 2 handing out pixels.
    logic [31:0] pix_q [$];
    int          posy_q [$];
    int          m_wx = 0, m_ly = 0, m_rx = 0, m_phase = 0;
    logic        m_took = 1'b0;
    logic        e_ready = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [11:0] e_posy = '0;
    logic [31:0] e_data = '0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pix_q.delete();
            posy_q.delete();
            m_wx = 0; m_ly = 0; m_rx = 0; m_phase = 0;
            e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_posy = '0; e_data = '0;
        end else begin
            m_took = S_VALID && e_ready;
            e_done = 1'b0;
            if (m_phase == 0) begin
                if (IN_DE) e_err = 1'b1;
                if (posy_q.size() > 0) begin
                    m_phase = 1;
                    e_done  = 1'b1;
                    e_posy  = 12'(posy_q[0]);
                end
            end else if (m_phase == 1) begin
                if (IN_DE) e_err = 1'b1;
                m_phase = 2;
            end else if (IN_DE) begin
                e_data = pix_q.pop_front();
                m_rx++;
                if (m_rx == W) begin
                    m_rx = 0;
                    void'(posy_q.pop_front());
                    m_phase = 0;
                end
            end
            if (m_took) begin
                pix_q.push_back(S_DATA);
                m_wx++;
                if (m_wx == W) begin
                    m_wx = 0;
                    posy_q.push_back(m_ly);
                    m_ly = (m_ly + 1) % H;
                end
            end
            e_ready = (posy_q.size() < 2);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        check("s_ready", S_READY, e_ready);
        check("read_line_done", READ_LINE_DONE, e_done);
        check("read_posy", READ_POSY, e_posy);
        check("in_data", IN_DATA, e_data);
        check("err", ERR, e_err);
    end

    // Announce log.
    always @(negedge CLK) begin
        if (RST && READ_LINE_DONE) begin
            ann_q.push_back(READ_POSY);
            ann_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_pixels(input int n, input int valid_pct, input int mode, input int base);
        int i = 0;
        int guard = 0;
        int hs_cyc;
        logic took;
        while (i < n) begin
            S_VALID = ($urandom_range(99) < valid_pct);
            S_DATA  = (mode == 0) ? 32'(base + i) : $urandom;
            took    = S_VALID && S_READY;
            hs_cyc  = cyc;
            tick();
            if (took) begin
                i++;
                beats_taken++;
                last_hs_cyc = hs_cyc;
            end
            guard++;
            if (guard > n * 20 + 20000) begin
                fail("producer_timeout");
                S_VALID = 1'b0;
                return;
            end
        end
        S_VALID = 1'b0;
    endtask

    task automatic consume(input bit wait_pulse, input int n_pix, input int de_pct, input int chk_base);
        int n = 0;
        int guard = 0;
        int de_cyc;
        if (wait_pulse) begin
            while (!READ_LINE_DONE) begin
                tick();
                guard++;
                if (guard > 40000) begin
                    fail("announce_timeout");
                    return;
                end
            end
            tick();
        end
        guard = 0;
        while (n < n_pix) begin
            IN_DE  = ($urandom_range(99) < de_pct);
            de_cyc = cyc;
            tick();
            if (IN_DE) begin
                if (chk_base >= 0) check("in_data_literal", IN_DATA, 32'(chk_base + n));
                n++;
                last_de_cyc = de_cyc;
            end
            guard++;
            if (guard > n_pix * 50 + 100) begin
                fail("consumer_timeout");
                IN_DE = 1'b0;
                return;
            end
        end
        IN_DE = 1'b0;
    endtask

    task automatic wait_ann(input int count, input string name);
        int guard = 0;
        while (ann_q.size() < count) begin
            tick();
            guard++;
            if (guard > 40000) begin
                fail(name);
                return;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b0; S_VALID = 1'b0; IN_DE = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset behaviour
        repeat (4) tick();
        check("rst_s_ready", S_READY, 0);
        check("rst_done", READ_LINE_DONE, 0);
        check("rst_posy", READ_POSY, 0);
        check("rst_in_data", IN_DATA, 0);
        check("rst_err", ERR, 0);
        RST = 1'b1;
        check("s_ready_before_edge", S_READY, 0);
        tick();
        check("s_ready_after_release", S_READY, 1);
        ann_q.delete();
        repeat (100) tick();
        check("no_announce_100", ann_q.size(), 0);

        // Single line, pixels 0..W-1
        send_pixels(W, 100, 0, 0);
        wait_ann(1, "single_announce_timeout");
        check("single_latency", ann_cyc - last_hs_cyc, 2);
        check("single_posy", ann_q[0], 0);
        consume(0, W, 100, 0);

        // Backpressure
        do_reset();
        ann_q.delete();
        beats_taken = 0;
        fork
            send_pixels(3 * W, 100, 1, 0);
            begin
                int guard = 0;
                while (beats_taken < 2 * W && guard < 20000) begin
                    tick();
                    guard++;
                end
                repeat (3) tick();
                check("bp_s_ready_low", S_READY, 0);
                check("bp_beats_taken", beats_taken, 2 * W);
                check("bp_announces", ann_q.size(), 1);
                consume(0, W, 100, -1);
                check("bp_s_ready_back", S_READY, 1);
                wait_ann(2, "bp_second_announce_timeout");
                check("bp_gap", ann_cyc - last_de_cyc, 2);
                check("bp_second_posy", ann_q[1], 1);
                consume(0, W, 70, -1);
                consume(1, W, 70, -1);
            end
        join

        // Y wrap with random traffic on both sides
        do_reset();
        ann_q.delete();
        fork
            send_pixels((H + 1) * W, 85, 1, 0);
            for (int l = 0; l < H + 1; l++) consume(1, W, 80, -1);
        join
        check("wrap_count", ann_q.size(), H + 1);
        check("wrap_m2", ann_q[H - 2], H - 2);
        check("wrap_m1", ann_q[H - 1], H - 1);
        check("wrap_zero", ann_q[H], 0);

        // Protocol error in IDLE
        repeat (3) tick();
        check("err_before", ERR, 0);
        IN_DE = 1'b1;
        tick();
        IN_DE = 1'b0;
        tick();
        check("err_set", ERR, 1);
        send_pixels(W, 90, 0, 1000);
        consume(1, W, 100, 1000);
        check("err_sticky", ERR, 1);

        // Reset mid-serve with the other bank half filled
        ann_q.delete();
        send_pixels(W, 100, 0, 5000);
        wait_ann(1, "mid_announce_timeout");
        send_pixels(W / 2, 100, 0, 7000);
        consume(0, W / 2, 100, 5000);
        RST = 1'b0;
        #2;
        check("mid_rst_s_ready", S_READY, 0);
        check("mid_rst_done", READ_LINE_DONE, 0);
        check("mid_rst_posy", READ_POSY, 0);
        check("mid_rst_in_data", IN_DATA, 0);
        check("mid_rst_err", ERR, 0);
        tick();
        RST = 1'b1;
        tick();
        ann_q.delete();
        send_pixels(W, 100, 0, 9000);
        wait_ann(1, "fresh_announce_timeout");
        check("fresh_posy", ann_q[0], 0);
        consume(0, W, 100, 9000);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_feeder.md
# line_feeder

Upstream partner of the per-line processing wrapper. Accepts a pixel stream from the frame reader and buffers it one line at a time in a ping-pong line RAM. For each buffered line it pulses `READ_LINE_DONE` with the line's Y position, then serves pixels on `IN_DATA` as the wrapper pulls them with `IN_DE`. Double buffering lets line N+1 fill while line N is consumed.

## Interface
- `WIDTH`, 1600: pixels per line.
- `HEIGHT`, 900: lines per frame; Y counter wraps after `HEIGHT-1`.
- `DATA_W`, 32: pixel word, {R,G,B,pad}.

Ports:
- `CLK`  in  1  single clock.
- `RST`  in  1  asynchronous, active-low reset.
- `S_VALID`  in  1  upstream pixel valid.
- `S_READY`  out  1  upstream pixel accept.
- `S_DATA`  in  32  upstream pixel.
- `READ_LINE_DONE`  out  1  one-cycle pulse: a full line is ready to serve.
- `READ_POSY`  out  12  Y of the announced line; held until the next announce.
- `IN_DE`  in  1  pixel pull from the consumer.
- `IN_DATA`  out  32  pulled pixel.
- `ERR`  out  1  sticky: `IN_DE` seen while not serving.

## Operation
- Two banks, each `WIDTH` words.
- Per-bank state: `full[b]` flag and a latched `posy[b]`.
- Write bank pointer `wb`, read bank pointer `rb`, 12-bit counters `wx`, `rx` and `ly`.
- **Fill side:**
  - `S_READY = !full[wb]`, combinational from registered flags.
  - On each handshake, write `S_DATA` to RAM[{wb,wx}] and increment `wx`.
  - On the handshake with `wx==WIDTH-1`: set `full[wb]`, `posy[wb]<=ly`, `wx<=0`, toggle `wb`.
  - On the same handshake `ly` increments, wrapping from `HEIGHT-1` to 0.
- **Serve FSM** (IDLE, ANNOUNCE, SERVE):
  - IDLE → ANNOUNCE when `full[rb]`.
  - ANNOUNCE: `READ_LINE_DONE`=1 for exactly this cycle; `READ_POSY<=posy[rb]`; `rx<=0`; go to SERVE.
  - SERVE: each `IN_DE` reads RAM[{rb,rx}] and increments `rx`.
  - On `IN_DE` with `rx==WIDTH-1`: clear `full[rb]`, toggle `rb`, go to IDLE.
- `IN_DE` in IDLE or ANNOUNCE: ignored (no read, no count), sets `ERR`. Only reset clears `ERR`.
- Fill and serve flag updates in the same cycle always touch different banks. Both apply.
- Upstream stalls (`S_VALID`=0) are legal at any point; `wx` holds.
- **Reset (any time, including mid-line):**
  - Banks empty, `wb`=`rb`=0, counters 0, FSM IDLE.
  - Outputs: `S_READY` 0 while reset is asserted, 1 from the first cycle after; `READ_LINE_DONE` 0; `READ_POSY` 0; `IN_DATA` 0; `ERR` 0.
  - Partial-line data is discarded.

## Timing
- Last-pixel handshake at cycle t: `full` set at t+1. If the FSM is IDLE, `READ_LINE_DONE` is high at t+2.
- `READ_POSY` is valid in the same cycle as the pulse.
- `IN_DATA` is registered: the pixel for an `IN_DE` at cycle k is valid at k+1 and holds until the next `IN_DE`.
- Back-to-back `IN_DE` gives one pixel per cycle.
- Next-line announce after the last `IN_DE` at cycle k: IDLE at k+1, ANNOUNCE (pulse) at k+2 if the next bank is full. This gives a two-cycle gap between lines.
- Upstream throughput is one pixel per cycle while a bank is free. `S_READY` drops the cycle after the second bank fills.

## Structure
- Shared package: `WIDTH`, `HEIGHT`, `DATA_W`, the 12-bit position type, and the serve FSM state encoding. These are shared with the processing wrapper so line length is defined once.
- One sub-module, `line_bank_ram`:
  - Simple dual-port memory, `2*WIDTH` x `DATA_W`, address {bank, x}.
  - One write port; one read port with registered output (1-cycle latency).
  - Inferred as BRAM.
  - Its output register is `IN_DATA`, with reset to 0.

## Test plan
- **Reset:** hold `RST`=0 → all outputs 0. Release → `S_READY`=1 next cycle; no `READ_LINE_DONE` for 100 cycles.
- **Single line:** stream pixels 0..1599 continuously with `IN_DE` idle → `READ_LINE_DONE` exactly 2 cycles after the last beat, `READ_POSY`=0. Then 1600 back-to-back `IN_DE` → `IN_DATA` equals 0..1599, each one cycle after its `IN_DE`.
- **Backpressure:** stream 3 lines with no consumption → `S_READY` low after beat 3200. Consume one line → `S_READY` reasserts; line 2 is announced with `READ_POSY`=1 two cycles after the last `IN_DE`.
- **Y wrap:** stream 901 lines, consuming continuously → announced `READ_POSY` sequence ends 898, 899, 0.
- **Error:** pulse `IN_DE` in IDLE → `ERR`=1 and stays 1; `IN_DATA` unchanged; the next line still serves from pixel 0.
- **Reset mid-operation:** assert `RST` at pixel 800 of serve while the other bank is half filled → outputs 0. After release, a fresh line is announced with `READ_POSY`=0 and its pixels are correct.
